// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter: FSM states, bus owner
// encoding, default limits and the counter-width helper.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    CPU_PRI  = 2'd0,
    DMA_PRI  = 2'd1,
    DMA_LOCK = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_C = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

  localparam int unsigned DefMaxWait = 4;
  localparam int unsigned DefMaxLock = 8;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with clear. Clear together with inc loads 1, so a new
// run can start counting in the same cycle the previous one is discarded.
module arb_sat_counter #(
  parameter int unsigned Width  = 4,
  parameter int unsigned MaxVal = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [Width-1:0] count
);

  localparam logic [Width-1:0] Max = Width'(MaxVal);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = (inc && (MaxVal != 0)) ? Width'(1) : '0;
    end else if (inc && (count_q != Max)) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-memory port between the core (C) and a DMA loader (D).
// Optional macro DMEM_ARB_STATS_EN adds saturating stall / D-grant statistics outputs.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DefMaxWait,
  parameter int unsigned MAX_LOCK = DefMaxLock,
  parameter int unsigned AW       = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [31:0]   c_wd,
  output logic          c_gnt,
  output logic          c_stall,
  output logic [31:0]   c_rd,
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_lock,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wd,
  output logic          d_gnt,
  output logic [31:0]   d_rd,
  output logic          d_rvalid,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wd,
  input  logic [31:0]   m_rd
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]   stat_stall,
  output logic [31:0]   stat_dgnt
`endif
);

  localparam int unsigned WaitW = cnt_width(MAX_WAIT - 1);
  localparam int unsigned LockW = cnt_width(MAX_LOCK);

  arb_state_e       state_q, state_d;
  arb_owner_e       owner;
  logic [WaitW-1:0] wait_cnt;
  logic [LockW-1:0] lock_cnt;
  logic             in_lock, wait_hit, lock_start, lock_exit;
  logic [31:0]      d_rd_q;
  logic             d_rvalid_q;

  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    unique case (state_q)
      CPU_PRI: begin
        c_gnt = c_req;
        d_gnt = d_req & ~c_req;
      end
      DMA_PRI: begin
        d_gnt = d_req;
        c_gnt = c_req & ~d_req;
      end
      DMA_LOCK: d_gnt = d_req;
      default: ;
    endcase
  end

  assign c_stall = c_req & ~c_gnt;
  assign owner   = d_gnt ? OWN_D : OWN_C;
  assign m_addr  = (owner == OWN_D) ? d_addr : c_addr;
  assign m_wd    = (owner == OWN_D) ? d_wd : c_wd;
  assign m_we    = (c_gnt & c_we) | (d_gnt & d_we);
  assign c_rd    = m_rd;

  assign in_lock    = (state_q == DMA_LOCK);
  assign wait_hit   = (wait_cnt == WaitW'(MAX_WAIT - 1));
  // A one-grant burst limit never needs the locked state.
  assign lock_start = ~in_lock & d_gnt & d_lock & (MAX_LOCK > 1);
  // lock_cnt counts earlier grants, so MAX_LOCK-1 means this grant closes the burst.
  assign lock_exit  = in_lock & (~d_req | ~d_lock | (lock_cnt == LockW'(MAX_LOCK - 1)));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CPU_PRI: begin
        if (lock_start)                         state_d = DMA_LOCK;
        else if (d_req && !d_gnt && wait_hit)   state_d = DMA_PRI;
      end
      DMA_PRI:  state_d = lock_start ? DMA_LOCK : CPU_PRI;
      DMA_LOCK: if (lock_exit) state_d = CPU_PRI;
      default:  state_d = CPU_PRI;
    endcase
  end

  arb_sat_counter #(
    .Width  (WaitW),
    .MaxVal (MAX_WAIT - 1)
  ) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (d_gnt | ~d_req),
    .inc   (d_req & ~d_gnt),
    .count (wait_cnt)
  );

  arb_sat_counter #(
    .Width  (LockW),
    .MaxVal (MAX_LOCK)
  ) u_lock_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (~in_lock | lock_exit),
    .inc   (lock_start | (in_lock & d_gnt & ~lock_exit)),
    .count (lock_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= CPU_PRI;
      d_rd_q     <= '0;
      d_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      d_rvalid_q <= d_gnt & ~d_we;
      if (d_gnt && !d_we) d_rd_q <= m_rd;
    end
  end

  assign d_rd     = d_rd_q;
  assign d_rvalid = d_rvalid_q;

`ifdef DMEM_ARB_STATS_EN
  arb_sat_counter #(
    .Width  (32),
    .MaxVal (32'hFFFF_FFFF)
  ) u_stat_stall (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (c_stall),
    .count (stat_stall)
  );

  arb_sat_counter #(
    .Width  (32),
    .MaxVal (32'hFFFF_FFFF)
  ) u_stat_dgnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (d_gnt),
    .count (stat_dgnt)
  );
`endif

endmodule
